// File: rtl/id_stage_fwd.sv
// Decode stage: register file with SP port, EX/MEM/POP/WB operand forwarding, ALU-source mux, ID/EX slot.
// Latency: one cycle from acceptance (in_valid & in_ready) to out_valid; the register file reads combinationally.
// Backpressure: the slot holds while out_valid & !ex_ready; a load-use hazard inserts a bubble; flush overrides both.
module id_stage_fwd #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned SP_IDX   = 29,
  parameter logic [31:0] SP_RESET = 32'h00000FFF,
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned JIMM_W   = 26,
  parameter int unsigned SHAMT_W  = 5,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RA_W-1:0]     rd,
  input  logic [RA_W-1:0]     rs,
  input  logic [RA_W-1:0]     rt,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [IMM_W-1:0]    imm,
  input  logic [JIMM_W-1:0]   jimm,
  input  logic [DATA_W-1:0]   pc,
  input  logic                call,
  input  logic                ret,
  input  logic                branch,
  input  logic                push,
  input  logic                pop,
  input  logic                reg2_sel,
  input  logic                sext_sel,
  input  logic                rd1_en,
  input  logic                rd2_en,
  input  logic                reg_write,
  input  logic                mem_read,
  input  logic [1:0]          alu_src,
  input  logic                wb_we,
  input  logic [RA_W-1:0]     wb_reg,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                pop_we,
  input  logic [DATA_W-1:0]   pop_data,
  input  logic                ex_we,
  input  logic [RA_W-1:0]     ex_reg,
  input  logic [DATA_W-1:0]   ex_data,
  input  logic                ex_is_load,
  input  logic                mem_we,
  input  logic [RA_W-1:0]     mem_reg,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                flush,
  input  logic                ex_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_a,
  output logic [DATA_W-1:0]   out_b,
  output logic [DATA_W-1:0]   out_store,
  output logic [DATA_W-1:0]   out_pc,
  output logic [IMM_W-1:0]    out_imm,
  output logic [RA_W-1:0]     out_dest,
  output logic [RA_W-1:0]     out_src1,
  output logic [RA_W-1:0]     out_src2,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int unsigned       DEPTH    = 2 ** RA_W;
  localparam logic [RA_W-1:0]   SP_A     = RA_W'(SP_IDX);
  localparam logic [DATA_W-1:0] SP_RST_V = DATA_W'(SP_RESET);

  // Register file storage.
  logic [DATA_W-1:0] rf_q [DEPTH];

  // Decode-side combinational signals.
  logic              sp_op;
  logic [RA_W-1:0]   src1;
  logic [RA_W-1:0]   src2;
  logic [RA_W-1:0]   dest;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              hz;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] jimm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] shamt_zext;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;

  // Output slot state and next state.
  logic              out_valid_q,     out_valid_d;
  logic [DATA_W-1:0] out_a_q,         out_a_d;
  logic [DATA_W-1:0] out_b_q,         out_b_d;
  logic [DATA_W-1:0] out_store_q,     out_store_d;
  logic [DATA_W-1:0] out_pc_q,        out_pc_d;
  logic [IMM_W-1:0]  out_imm_q,       out_imm_d;
  logic [RA_W-1:0]   out_dest_q,      out_dest_d;
  logic [RA_W-1:0]   out_src1_q,      out_src1_d;
  logic [RA_W-1:0]   out_src2_q,      out_src2_d;
  logic              out_reg_write_q, out_reg_write_d;
  logic              out_mem_read_q,  out_mem_read_d;
  logic [CNT_W-1:0]  stall_cnt_q,     stall_cnt_d;

  // Two write ports; POP is applied last so it wins a collision on SP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        rf_q[i] <= (i == int'(SP_IDX)) ? SP_RST_V : '0;
      end
    end else begin
      if (wb_we) begin
        rf_q[wb_reg] <= wb_data;
      end
      if (pop_we) begin
        rf_q[SP_A] <= pop_data;
      end
    end
  end

  // Stack operations implicitly address SP; call/ret/push also write it.
  assign sp_op = call | ret | push | pop;
  assign src1  = sp_op ? SP_A : rs;
  assign src2  = reg2_sel ? rt : rd;
  assign dest  = (call | ret | push) ? SP_A : rd;

  // Source 1 value: youngest producer first; a load in EX cannot forward yet.
  always_comb begin
    op1 = rf_q[src1];
    if (!rd1_en) begin
      op1 = '0;
    end else if (ex_we && (ex_reg == src1) && !ex_is_load) begin
      op1 = ex_data;
    end else if (mem_we && (mem_reg == src1)) begin
      op1 = mem_data;
    end else if (pop_we && (src1 == SP_A)) begin
      op1 = pop_data;
    end else if (wb_we && (wb_reg == src1)) begin
      op1 = wb_data;
    end
  end

  // Source 2 value: same priority as source 1.
  always_comb begin
    op2 = rf_q[src2];
    if (!rd2_en) begin
      op2 = '0;
    end else if (ex_we && (ex_reg == src2) && !ex_is_load) begin
      op2 = ex_data;
    end else if (mem_we && (mem_reg == src2)) begin
      op2 = mem_data;
    end else if (pop_we && (src2 == SP_A)) begin
      op2 = pop_data;
    end else if (wb_we && (wb_reg == src2)) begin
      op2 = wb_data;
    end
  end

  // A load in EX whose result a live source needs forces a one-cycle bubble.
  assign hz = in_valid & ex_we & ex_is_load &
              ((rd1_en & (ex_reg == src1)) | (rd2_en & (ex_reg == src2)));

  // Flush always drains the input so the front end can redirect.
  assign in_ready = flush | (~hz & (~out_valid_q | ex_ready));

  assign imm_sext   = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
  assign jimm_sext  = {{(DATA_W - JIMM_W){jimm[JIMM_W-1]}}, jimm};
  assign imm_zext   = {{(DATA_W - IMM_W){1'b0}}, imm};
  assign shamt_zext = {{(DATA_W - SHAMT_W){1'b0}}, shamt};

  // ALU operand selection; SP adjust uses a constant step of one.
  always_comb begin
    alu_a = op1;
    alu_b = op2;
    case (alu_src)
      2'b01: begin
        alu_a = branch ? pc : op1;
        alu_b = sext_sel ? jimm_sext : imm_sext;
      end
      2'b10: begin
        alu_b = sp_op ? DATA_W'(1) : shamt_zext;
      end
      2'b11: begin
        alu_a = '0;
        alu_b = imm_zext << 16;
      end
      default: begin
      end
    endcase
  end

  // Slot next state: flush, then hold under backpressure, then bubble, then load.
  always_comb begin
    out_valid_d     = out_valid_q;
    out_a_d         = out_a_q;
    out_b_d         = out_b_q;
    out_store_d     = out_store_q;
    out_pc_d        = out_pc_q;
    out_imm_d       = out_imm_q;
    out_dest_d      = out_dest_q;
    out_src1_d      = out_src1_q;
    out_src2_d      = out_src2_q;
    out_reg_write_d = out_reg_write_q;
    out_mem_read_d  = out_mem_read_q;
    stall_cnt_d     = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && !ex_ready) begin
      out_valid_d = out_valid_q;
    end else if (hz) begin
      out_valid_d = 1'b0;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      out_valid_d     = in_valid;
      out_a_d         = alu_a;
      out_b_d         = alu_b;
      out_store_d     = op2;
      out_pc_d        = pc;
      out_imm_d       = imm;
      out_dest_d      = dest;
      out_src1_d      = src1;
      out_src2_d      = src2;
      out_reg_write_d = reg_write;
      out_mem_read_d  = mem_read;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q     <= 1'b0;
      out_a_q         <= '0;
      out_b_q         <= '0;
      out_store_q     <= '0;
      out_pc_q        <= '0;
      out_imm_q       <= '0;
      out_dest_q      <= '0;
      out_src1_q      <= '0;
      out_src2_q      <= '0;
      out_reg_write_q <= 1'b0;
      out_mem_read_q  <= 1'b0;
      stall_cnt_q     <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_a_q         <= out_a_d;
      out_b_q         <= out_b_d;
      out_store_q     <= out_store_d;
      out_pc_q        <= out_pc_d;
      out_imm_q       <= out_imm_d;
      out_dest_q      <= out_dest_d;
      out_src1_q      <= out_src1_d;
      out_src2_q      <= out_src2_d;
      out_reg_write_q <= out_reg_write_d;
      out_mem_read_q  <= out_mem_read_d;
      stall_cnt_q     <= stall_cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_a         = out_a_q;
  assign out_b         = out_b_q;
  assign out_store     = out_store_q;
  assign out_pc        = out_pc_q;
  assign out_imm       = out_imm_q;
  assign out_dest      = out_dest_q;
  assign out_src1      = out_src1_q;
  assign out_src2      = out_src2_q;
  assign out_reg_write = out_reg_write_q;
  assign out_mem_read  = out_mem_read_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: directed scenarios then random traffic against a behavioural model.
// Latency: outputs are compared one cycle after each driven step.
// Backpressure: ex_ready and flush are driven both directed and at random.
module tb_id_stage_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  rd, rs, rt;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] jimm;
  logic [31:0] pc;
  logic        call, ret, branch, push, pop;
  logic        reg2_sel, sext_sel, rd1_en, rd2_en, reg_write, mem_read;
  logic [1:0]  alu_src;
  logic        wb_we;   logic [4:0] wb_reg;  logic [31:0] wb_data;
  logic        pop_we;  logic [31:0] pop_data;
  logic        ex_we;   logic [4:0] ex_reg;  logic [31:0] ex_data; logic ex_is_load;
  logic        mem_we;  logic [4:0] mem_reg; logic [31:0] mem_data;
  logic        flush, ex_ready;
  logic        out_valid;
  logic [31:0] out_a, out_b, out_store, out_pc;
  logic [15:0] out_imm;
  logic [4:0]  out_dest, out_src1, out_src2;
  logic        out_reg_write, out_mem_read;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_a, m_b, m_store, m_pc;
  logic [15:0] m_imm;
  logic [4:0]  m_dest, m_s1, m_s2;
  logic        m_rw, m_mr;
  int          m_stall;

  always #5 clk = ~clk;

  id_stage_fwd dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .imm(imm), .jimm(jimm), .pc(pc),
    .call(call), .ret(ret), .branch(branch), .push(push), .pop(pop),
    .reg2_sel(reg2_sel), .sext_sel(sext_sel), .rd1_en(rd1_en), .rd2_en(rd2_en),
    .reg_write(reg_write), .mem_read(mem_read), .alu_src(alu_src),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .pop_we(pop_we), .pop_data(pop_data),
    .ex_we(ex_we), .ex_reg(ex_reg), .ex_data(ex_data), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_reg(mem_reg), .mem_data(mem_data),
    .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_store(out_store),
    .out_pc(out_pc), .out_imm(out_imm), .out_dest(out_dest),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; rd = 0; rs = 0; rt = 0; shamt = 0; imm = 0; jimm = 0; pc = 0;
    call = 0; ret = 0; branch = 0; push = 0; pop = 0;
    reg2_sel = 0; sext_sel = 0; rd1_en = 0; rd2_en = 0; reg_write = 0; mem_read = 0;
    alu_src = 0; wb_we = 0; wb_reg = 0; wb_data = 0; pop_we = 0; pop_data = 0;
    ex_we = 0; ex_reg = 0; ex_data = 0; ex_is_load = 0;
    mem_we = 0; mem_reg = 0; mem_data = 0; flush = 0; ex_ready = 1;
  endtask

  // Value an instruction sees for a source: newest pipeline producer, then the file.
  function automatic logic [31:0] m_operand(input logic en, input logic [4:0] src);
    if (!en) return 32'd0;
    if (ex_we && ex_reg == src && !ex_is_load) return ex_data;
    if (mem_we && mem_reg == src) return mem_data;
    if (pop_we && src == 5'd29) return pop_data;
    if (wb_we && wb_reg == src) return wb_data;
    return m_rf[src];
  endfunction

  // One clock: check in_ready, advance the model, then check the slot.
  task automatic step(input string tag);
    logic        sp_op, hz, exp_rdy, n_valid;
    logic [4:0]  s1, s2;
    logic [31:0] o1, o2, a, b;
    sp_op = call | ret | push | pop;
    s1 = sp_op ? 5'd29 : rs;
    s2 = reg2_sel ? rt : rd;
    hz = in_valid && ex_we && ex_is_load &&
         ((rd1_en && ex_reg == s1) || (rd2_en && ex_reg == s2));
    o1 = m_operand(rd1_en, s1);
    o2 = m_operand(rd2_en, s2);
    case (alu_src)
      2'd0: begin a = o1; b = o2; end
      2'd1: begin a = branch ? pc : o1; b = sext_sel ? 32'($signed(jimm)) : 32'($signed(imm)); end
      2'd2: begin a = o1; b = sp_op ? 32'd1 : 32'(shamt); end
      default: begin a = 32'd0; b = {imm, 16'h0000}; end
    endcase
    exp_rdy = flush || (!hz && (!m_valid || ex_ready));
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    n_valid = m_valid;
    if (flush) n_valid = 0;
    else if (m_valid && !ex_ready) n_valid = 1;
    else if (hz) begin
      n_valid = 0;
      if (m_stall < 65535) m_stall = m_stall + 1;
    end else begin
      n_valid = in_valid;
      m_a = a; m_b = b; m_store = o2; m_pc = pc; m_imm = imm;
      m_dest = (call || ret || push) ? 5'd29 : rd;
      m_s1 = s1; m_s2 = s2; m_rw = reg_write; m_mr = mem_read;
    end
    if (wb_we) m_rf[wb_reg] = wb_data;
    if (pop_we) m_rf[29] = pop_data;
    @(posedge clk);
    m_valid = n_valid;
    #1;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    if (m_valid) begin
      chk({tag, ".out_a"}, 64'(out_a), 64'(m_a));
      chk({tag, ".out_b"}, 64'(out_b), 64'(m_b));
      chk({tag, ".out_store"}, 64'(out_store), 64'(m_store));
      chk({tag, ".out_pc"}, 64'(out_pc), 64'(m_pc));
      chk({tag, ".out_imm"}, 64'(out_imm), 64'(m_imm));
      chk({tag, ".out_dest"}, 64'(out_dest), 64'(m_dest));
      chk({tag, ".out_src1"}, 64'(out_src1), 64'(m_s1));
      chk({tag, ".out_src2"}, 64'(out_src2), 64'(m_s2));
      chk({tag, ".out_ctl"}, 64'({out_reg_write, out_mem_read}), 64'({m_rw, m_mr}));
    end
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd29 : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = (i == 29) ? 32'h0FFF : 32'd0;
    m_valid = 0; m_a = 0; m_b = 0; m_store = 0; m_pc = 0; m_imm = 0;
    m_dest = 0; m_s1 = 0; m_s2 = 0; m_rw = 0; m_mr = 0; m_stall = 0;
    idle();
    rst = 0;
    #12;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset.out_a", 64'(out_a), 64'd0);
    chk("reset.out_dest", 64'(out_dest), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    #5 rst = 1;

    // Read reset SP through a PUSH with the increment source.
    idle(); in_valid = 1; push = 1; rd1_en = 1; alu_src = 2'b10; reg_write = 1;
    step("t1_push");
    chk("t1.sp_a", 64'(out_a), 64'h0FFF);
    chk("t1.sp_b", 64'(out_b), 64'd1);
    chk("t1.dest", 64'(out_dest), 64'd29);

    // EX and MEM forwarding on distinct sources, then on the same source.
    idle(); in_valid = 1; rs = 3; rt = 4; rd = 6; reg2_sel = 1; rd1_en = 1; rd2_en = 1;
    ex_we = 1; ex_reg = 3; ex_data = 5; mem_we = 1; mem_reg = 4; mem_data = 7;
    step("t2_fwd");
    chk("t2.a_ex", 64'(out_a), 64'd5);
    chk("t2.b_mem", 64'(out_b), 64'd7);
    mem_reg = 3;
    step("t2_prio");
    chk("t2.ex_wins", 64'(out_a), 64'd5);

    // Load-use bubble, then the loaded value arrives via MEM.
    idle(); in_valid = 1; rs = 3; rd1_en = 1; ex_we = 1; ex_is_load = 1; ex_reg = 3;
    #1 chk("t3.in_ready_low", 64'(in_ready), 64'd0);
    step("t3_stall");
    chk("t3.stall_one", 64'(stall_cnt), 64'd1);
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_reg = 3; mem_data = 9;
    step("t3_resume");
    chk("t3.mem_fwd", 64'(out_a), 64'd9);

    // Backpressure holds the slot for three cycles.
    idle(); in_valid = 1; rs = 5; rd1_en = 1; pc = 32'h44; ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("t4_hold");
      chk("t4.held_a", 64'(out_a), 64'd9);
    end
    ex_ready = 1;
    step("t4_release");
    chk("t4.new_pc", 64'(out_pc), 64'h44);

    // Flush during a load-use stall and during backpressure.
    idle(); in_valid = 1; rs = 3; rd1_en = 1; ex_we = 1; ex_is_load = 1; ex_reg = 3; flush = 1;
    step("t5_flush_stall");
    chk("t5.stall_kept", 64'(stall_cnt), 64'd1);
    idle(); in_valid = 1;
    step("t5_fill");
    ex_ready = 0; flush = 1;
    step("t5_flush_bp");
    chk("t5.bp_flushed", 64'(out_valid), 64'd0);

    // POP and WB both target SP: POP wins, and a same-cycle read sees it.
    idle(); in_valid = 1; push = 1; rd1_en = 1; pop_we = 1; pop_data = 32'h0FFE;
    wb_we = 1; wb_reg = 29; wb_data = 32'h1234;
    step("t6_collide");
    chk("t6.same_cycle", 64'(out_a), 64'h0FFE);
    idle(); in_valid = 1; push = 1; rd1_en = 1;
    step("t6_after");
    chk("t6.stored", 64'(out_a), 64'h0FFE);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      rd = rnd_reg(); rs = rnd_reg(); rt = rnd_reg();
      shamt = 5'($urandom); imm = 16'($urandom); jimm = 26'($urandom); pc = $urandom;
      call = ($urandom_range(0, 7) == 0); ret = ($urandom_range(0, 7) == 0);
      push = ($urandom_range(0, 7) == 0); pop = ($urandom_range(0, 7) == 0);
      branch = 1'($urandom); reg2_sel = 1'($urandom); sext_sel = 1'($urandom);
      rd1_en = 1'($urandom); rd2_en = 1'($urandom);
      reg_write = 1'($urandom); mem_read = 1'($urandom); alu_src = 2'($urandom);
      wb_we = 1'($urandom); wb_reg = rnd_reg(); wb_data = $urandom;
      pop_we = ($urandom_range(0, 3) == 0); pop_data = $urandom;
      ex_we = 1'($urandom); ex_reg = rnd_reg(); ex_data = $urandom; ex_is_load = 1'($urandom);
      mem_we = 1'($urandom); mem_reg = rnd_reg(); mem_data = $urandom;
      flush = ($urandom_range(0, 11) == 0); ex_ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
